// File: rtl/bp_be_dcache_stat_gen.sv
// D$ statistics producer: counts accesses/hits/misses after a warmup window and
// streams a frozen snapshot as three tagged words over a valid/ready port.
module bp_be_dcache_stat_gen #(
  parameter int unsigned ctr_width_p    = 64,
  parameter int unsigned warmup_width_p = 30
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      freeze_i,
  input  logic                      clear_i,
  input  logic [warmup_width_p-1:0] warmup_instr_i,
  input  logic                      commit_v_i,
  input  logic                      access_v_i,
  input  logic                      access_hit_i,
  input  logic                      snapshot_i,
  output logic                      stat_v_o,
  input  logic                      stat_ready_i,
  output logic [1:0]                stat_id_o,
  output logic [ctr_width_p-1:0]    stat_data_o,
  output logic                      done_o,
  output logic [ctr_width_p-1:0]    access_count_o,
  output logic [ctr_width_p-1:0]    hit_count_o,
  output logic [ctr_width_p-1:0]    miss_count_o
);

  typedef enum logic [2:0] {
    e_warmup,
    e_count,
    e_dump_acc,
    e_dump_hit,
    e_dump_miss,
    e_done
  } state_e;

  state_e                    state_q, state_d;
  logic [warmup_width_p-1:0] warm_cnt_q, warm_cnt_d;
  logic [ctr_width_p-1:0]    acc_q, acc_d, hit_q, hit_d, miss_q, miss_d;
  logic [ctr_width_p-1:0]    snap_acc_q, snap_acc_d, snap_hit_q, snap_hit_d;
  logic [ctr_width_p-1:0]    snap_miss_q, snap_miss_d;
  logic                      snap_dly_q;
  logic                      stat_v_q, stat_v_d;
  logic [1:0]                stat_id_q, stat_id_d;
  logic [ctr_width_p-1:0]    stat_data_q, stat_data_d;
  logic                      done_q, done_d;

  logic warm, count_en, capture, hs, sync_clr;

  assign sync_clr = clear_i | freeze_i;
  assign warm     = (warm_cnt_q == warmup_instr_i);
  assign hs       = stat_v_q & stat_ready_i;

  // Counting, capture and warmup datapath
  always_comb begin
    warm_cnt_d = warm_cnt_q;
    if (commit_v_i && !warm)
      warm_cnt_d = warm_cnt_q + warmup_width_p'(1);

    count_en = warm && ((state_q == e_warmup) || (state_q == e_count) || (state_q == e_done));

    acc_d  = acc_q;
    hit_d  = hit_q;
    miss_d = miss_q;
    if (count_en && access_v_i) begin
      if (acc_q != '1) acc_d = acc_q + ctr_width_p'(1);
      if (access_hit_i) begin
        if (hit_q != '1) hit_d = hit_q + ctr_width_p'(1);
      end else begin
        if (miss_q != '1) miss_d = miss_q + ctr_width_p'(1);
      end
    end

    // In e_done only a fresh rising edge restarts a dump so a held level is one request
    unique case (state_q)
      e_warmup, e_count: capture = snapshot_i;
      e_done:            capture = snapshot_i & ~snap_dly_q;
      default:           capture = 1'b0;
    endcase

    snap_acc_d  = capture ? acc_d  : snap_acc_q;
    snap_hit_d  = capture ? hit_d  : snap_hit_q;
    snap_miss_d = capture ? miss_d : snap_miss_q;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_warmup:    if (capture) state_d = e_dump_acc;
                   else if (warm) state_d = e_count;
      e_count:     if (capture) state_d = e_dump_acc;
      e_dump_acc:  if (hs) state_d = e_dump_hit;
      e_dump_hit:  if (hs) state_d = e_dump_miss;
      e_dump_miss: if (hs) state_d = e_done;
      e_done:      if (capture) state_d = e_dump_acc;
      default:     state_d = e_warmup;
    endcase
  end

  // Output logic, decoded from the next state so the stream port is fully registered
  always_comb begin
    stat_v_d    = 1'b0;
    stat_id_d   = 2'd0;
    stat_data_d = '0;
    unique case (state_d)
      e_dump_acc:  begin stat_v_d = 1'b1; stat_id_d = 2'd0; stat_data_d = snap_acc_d;  end
      e_dump_hit:  begin stat_v_d = 1'b1; stat_id_d = 2'd1; stat_data_d = snap_hit_d;  end
      e_dump_miss: begin stat_v_d = 1'b1; stat_id_d = 2'd2; stat_data_d = snap_miss_d; end
      default:     ;
    endcase
    done_d = (state_q == e_dump_miss) && hs;
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_warmup;
      warm_cnt_q  <= '0;
      acc_q       <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      snap_acc_q  <= '0;
      snap_hit_q  <= '0;
      snap_miss_q <= '0;
      snap_dly_q  <= 1'b0;
      stat_v_q    <= 1'b0;
      stat_id_q   <= 2'd0;
      stat_data_q <= '0;
      done_q      <= 1'b0;
    end else if (sync_clr) begin
      state_q     <= e_warmup;
      warm_cnt_q  <= '0;
      acc_q       <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      snap_acc_q  <= '0;
      snap_hit_q  <= '0;
      snap_miss_q <= '0;
      snap_dly_q  <= 1'b0;
      stat_v_q    <= 1'b0;
      stat_id_q   <= 2'd0;
      stat_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      acc_q       <= acc_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      snap_acc_q  <= snap_acc_d;
      snap_hit_q  <= snap_hit_d;
      snap_miss_q <= snap_miss_d;
      snap_dly_q  <= snapshot_i;
      stat_v_q    <= stat_v_d;
      stat_id_q   <= stat_id_d;
      stat_data_q <= stat_data_d;
      done_q      <= done_d;
    end
  end

  assign stat_v_o       = stat_v_q;
  assign stat_id_o      = stat_id_q;
  assign stat_data_o    = stat_data_q;
  assign done_o         = done_q;
  assign access_count_o = acc_q;
  assign hit_count_o    = hit_q;
  assign miss_count_o   = miss_q;

endmodule
